// File: rtl/cpu_input_driver.sv
`default_nettype none
// ============================================================================
// Module   : cpu_input_driver
// Purpose  : Stimulus driver for the CPU input-switch port. Bytes arrive on a
//            valid/ready write interface, are buffered in a small FIFO, and
//            are presented one at a time on in_port with a framed ready_in
//            strobe (setup / high / gap). The framing works for both the
//            CPU's level-sensitive ready wait and its rising-edge wait.
// Ports    : clk      - rising-edge clock shared with the CPU
//            reset    - synchronous, active-high reset
//            wr_data  - byte to enqueue
//            wr_valid - enqueue request
//            wr_ready - FIFO can accept (count < DEPTH)
//            in_port  - registered data to the CPU
//            ready_in - registered strobe to the CPU
//            count    - FIFO occupancy
//            busy     - frame in flight or bytes still buffered
// Revision : 1.0 - initial release
// ============================================================================
module cpu_input_driver #(
    parameter int BUS_WIDTH    = 8,
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BUS_WIDTH-1:0]         wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    output logic [BUS_WIDTH-1:0]         in_port,
    output logic                         ready_in,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam int C_MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int C_MAX_T  = (C_MAX_SH > GAP_CYCLES) ? C_MAX_SH : GAP_CYCLES;
    localparam int C_TMR_W  = $clog2(C_MAX_T + 1);

    localparam logic [C_CNT_W-1:0] C_DEPTH      = C_CNT_W'(DEPTH);
    localparam logic [C_TMR_W-1:0] C_SETUP_LOAD = C_TMR_W'(SETUP_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] C_HOLD_LOAD  = C_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] C_GAP_LOAD   = C_TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [BUS_WIDTH-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;
    state_t               r_state;
    logic [C_TMR_W-1:0]   r_timer;
    logic [BUS_WIDTH-1:0] r_in_port;
    logic                 r_ready_in;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                 w_push;
    logic                 w_pop;
    state_t               w_next_state;
    logic [C_TMR_W-1:0]   w_next_timer;

    // Acceptance depends only on the registered count, so a full FIFO
    // refuses a push even on the cycle it pops.
    assign wr_ready = (r_count < C_DEPTH);
    assign w_push   = wr_valid & wr_ready;

    assign in_port  = r_in_port;
    assign ready_in = r_ready_in;
    assign count    = r_count;
    assign busy     = (r_state != ST_IDLE) || (r_count != '0);

    // Next-state / timer logic. The shared down-counter is loaded with N-1
    // on entry to each timed state and the state advances when it hits 0.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SETUP;
                    w_next_timer = C_SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (r_timer == '0) begin
                    w_next_state = ST_STROBE;
                    w_next_timer = C_HOLD_LOAD;
                end else begin
                    w_next_timer = r_timer - 1'b1;
                end
            end
            ST_STROBE: begin
                if (r_timer == '0) begin
                    w_next_state = ST_GAP;
                    w_next_timer = C_GAP_LOAD;
                end else begin
                    w_next_timer = r_timer - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_timer == '0) begin
                    w_next_state = ST_IDLE;
                    w_next_timer = '0;
                end else begin
                    w_next_timer = r_timer - 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_timer = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_in_port  <= '0;
            r_ready_in <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_next_timer;
            // Registering the strobe from the next state keeps it exactly
            // aligned with STROBE occupancy, while in_port only moves on a
            // pop (from IDLE), so data never changes under a high strobe.
            r_ready_in <= (w_next_state == ST_STROBE);
            if (w_pop) begin
                r_in_port <= r_mem[r_rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_input_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_input_driver
// Purpose  : Directed self-checking bench for cpu_input_driver. A default
//            instance and a SETUP=3/HOLD=1/GAP=1 instance share clk/reset.
//            Cycle c is the interval after the c-th edge following reset
//            release; inputs set in cycle c are sampled at the edge ending it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_input_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data,  wr_data2;
    logic       wr_valid, wr_valid2;
    logic       wr_ready, wr_ready2;
    logic [7:0] in_port,  in_port2;
    logic       ready_in, ready_in2;
    logic [2:0] count,    count2;
    logic       busy,     busy2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_input_driver dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .in_port  (in_port),
        .ready_in (ready_in),
        .count    (count),
        .busy     (busy)
    );

    cpu_input_driver #(
        .BUS_WIDTH    (8),
        .DEPTH        (4),
        .SETUP_CYCLES (3),
        .HOLD_CYCLES  (1),
        .GAP_CYCLES   (1)
    ) dut2 (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data2),
        .wr_valid (wr_valid2),
        .wr_ready (wr_ready2),
        .in_port  (in_port2),
        .ready_in (ready_in2),
        .count    (count2),
        .busy     (busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        wr_valid  = 1'b0;
        wr_valid2 = 1'b0;
        wr_data   = 8'h00;
        wr_data2  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if (in_port !== 8'h00) begin
            fails++; $display("FAIL reset_in_port got %h exp 00", in_port);
        end
        tests++;
        if (ready_in !== 1'b0) begin
            fails++; $display("FAIL reset_ready_in got %b exp 0", ready_in);
        end
        tests++;
        if (count !== 3'd0) begin
            fails++; $display("FAIL reset_count got %0d exp 0", count);
        end
        tests++;
        if (wr_ready !== 1'b1) begin
            fails++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy got %b exp 0", busy);
        end
    endtask

    // Push 0xA5 at cycle 0: in_port from 2, strobe on 4-5, busy low from 8.
    task automatic test_single;
        logic [7:0] exp_port;
        logic       exp_rdy, exp_busy;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            exp_port = (c >= 2) ? 8'hA5 : 8'h00;
            exp_rdy  = (c == 4 || c == 5);
            exp_busy = (c >= 1 && c < 8);
            tests++;
            if (in_port !== exp_port) begin
                fails++; $display("FAIL single_in_port c=%0d got %h exp %h", c, in_port, exp_port);
            end
            tests++;
            if (ready_in !== exp_rdy) begin
                fails++; $display("FAIL single_ready_in c=%0d got %b exp %b", c, ready_in, exp_rdy);
            end
            tests++;
            if (busy !== exp_busy) begin
                fails++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, exp_busy);
            end
            wr_valid = (c == 0);
            wr_data  = 8'hA5;
        end
        wr_valid = 1'b0;
    endtask

    // Four consecutive pushes: rises at 4, 11, 18, 25 carrying 11..44.
    task automatic test_burst;
        logic [7:0] exp_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       prev_rdy;
        logic [7:0] prev_port;
        int         n;
        do_reset();
        n         = 0;
        prev_rdy  = 1'b0;
        prev_port = 8'h00;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) tick();
            if (ready_in && !prev_rdy) begin
                tests++;
                if (n >= 4 || c != 4 + 7 * n) begin
                    fails++; $display("FAIL burst_rise_cycle n=%0d got %0d exp %0d", n, c, 4 + 7 * n);
                end
                if (n < 4) begin
                    tests++;
                    if (in_port !== exp_vals[n]) begin
                        fails++; $display("FAIL burst_rise_data n=%0d got %h exp %h", n, in_port, exp_vals[n]);
                    end
                end
                n++;
            end
            if (ready_in && prev_rdy) begin
                tests++;
                if (in_port !== prev_port) begin
                    fails++; $display("FAIL burst_stable c=%0d got %h exp %h", c, in_port, prev_port);
                end
            end
            prev_rdy  = ready_in;
            prev_port = in_port;
            wr_valid  = (c < 4);
            wr_data   = 8'((c + 1) * 17);
        end
        wr_valid = 1'b0;
        tests++;
        if (n != 4) begin
            fails++; $display("FAIL burst_rise_count got %0d exp 4", n);
        end
    endtask

    // wr_valid held for cycles 0..9 with data = cycle number.
    // Accepted: 0,1,2,3,4 then full at 5..8 (8 is full+pop), 9 accepted.
    task automatic test_full;
        logic [7:0] exp_vals [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h09};
        logic       prev_rdy;
        int         n;
        do_reset();
        n        = 0;
        prev_rdy = 1'b0;
        for (int c = 0; c <= 50; c++) begin
            if (c > 0) tick();
            if (c == 5) begin
                tests++;
                if (count !== 3'd4) begin
                    fails++; $display("FAIL full_count5 got %0d exp 4", count);
                end
                tests++;
                if (wr_ready !== 1'b0) begin
                    fails++; $display("FAIL full_wr_ready5 got %b exp 0", wr_ready);
                end
            end
            if (c == 8) begin
                tests++;
                if (wr_ready !== 1'b0) begin
                    fails++; $display("FAIL full_wr_ready8 got %b exp 0", wr_ready);
                end
            end
            if (c == 9) begin
                tests++;
                if (count !== 3'd3) begin
                    fails++; $display("FAIL full_pop_refuse_count9 got %0d exp 3", count);
                end
                tests++;
                if (wr_ready !== 1'b1) begin
                    fails++; $display("FAIL full_wr_ready9 got %b exp 1", wr_ready);
                end
            end
            if (c == 10) begin
                tests++;
                if (count !== 3'd4) begin
                    fails++; $display("FAIL full_count10 got %0d exp 4", count);
                end
            end
            if (ready_in && !prev_rdy) begin
                tests++;
                if (n >= 6) begin
                    fails++; $display("FAIL full_extra_rise c=%0d got %h exp none", c, in_port);
                end else if (in_port !== exp_vals[n]) begin
                    fails++; $display("FAIL full_rise_data n=%0d got %h exp %h", n, in_port, exp_vals[n]);
                end
                n++;
            end
            prev_rdy = ready_in;
            wr_valid = (c <= 9);
            wr_data  = 8'(c);
        end
        wr_valid = 1'b0;
        tests++;
        if (n != 6) begin
            fails++; $display("FAIL full_rise_count got %0d exp 6", n);
        end
    endtask

    // Reset during STROBE (cycle 4) with two bytes still queued.
    task automatic test_reset_mid;
        int highs;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            wr_valid = (c <= 2);
            wr_data  = 8'(8'h55 + 8'(c * 17));
        end
        wr_valid = 1'b0;
        tests++;
        if (ready_in !== 1'b1 || count !== 3'd2) begin
            fails++; $display("FAIL mid_pre_state got rdy=%b cnt=%0d exp rdy=1 cnt=2", ready_in, count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (ready_in !== 1'b0) begin
            fails++; $display("FAIL mid_ready_in got %b exp 0", ready_in);
        end
        tests++;
        if (in_port !== 8'h00) begin
            fails++; $display("FAIL mid_in_port got %h exp 00", in_port);
        end
        tests++;
        if (count !== 3'd0) begin
            fails++; $display("FAIL mid_count got %0d exp 0", count);
        end
        highs = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (ready_in) highs++;
        end
        tests++;
        if (highs != 0) begin
            fails++; $display("FAIL mid_no_strobe got %0d exp 0", highs);
        end
        // A fresh push after the reset is framed normally.
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        for (int c = 1; c <= 5; c++) begin
            tick();
            wr_valid = 1'b0;
        end
        tests++;
        if (ready_in !== 1'b1 || in_port !== 8'h99) begin
            fails++; $display("FAIL mid_repush got rdy=%b data=%h exp rdy=1 data=99", ready_in, in_port);
        end
    endtask

    // SETUP=3, HOLD=1, GAP=1: single-cycle strobes at 5 and 11 (period 6).
    task automatic test_sweep;
        logic exp_rdy;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) tick();
            exp_rdy = (c == 5 || c == 11);
            tests++;
            if (ready_in2 !== exp_rdy) begin
                fails++; $display("FAIL sweep_ready_in c=%0d got %b exp %b", c, ready_in2, exp_rdy);
            end
            if (c == 5) begin
                tests++;
                if (in_port2 !== 8'h3C) begin
                    fails++; $display("FAIL sweep_data0 got %h exp 3c", in_port2);
                end
            end
            if (c == 11) begin
                tests++;
                if (in_port2 !== 8'hC3) begin
                    fails++; $display("FAIL sweep_data1 got %h exp c3", in_port2);
                end
            end
            wr_valid2 = (c <= 1);
            wr_data2  = (c == 0) ? 8'h3C : 8'hC3;
        end
        wr_valid2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
